// File: rtl/key_pio_ctrl.sv
// Debounced, edge-capturing input port with masked interrupt, exposed as an Avalon-MM slave.
// Raw pins are synchronised, optionally debounced, then edges latch into a sticky W1C register.
module key_pio_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_MASK = 2'd1;
    localparam logic [1:0]  ADDR_EDGE = 2'd2;
    localparam logic [1:0]  ADDR_CFG  = 2'd3;
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] stable_d_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [15:0]      cnt_r [WIDTH];
    logic             deb_en_r;
    logic [1:0]       edge_sel_r;

    logic             wr_s;
    logic [WIDTH-1:0] stable_next_s;
    logic [15:0]      cnt_next_s [WIDTH];
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] edgecap_next_s;
    logic [WIDTH-1:0] mask_next_s;
    logic             deb_en_next_s;
    logic [1:0]       edge_sel_next_s;
    logic [31:0]      rdata_s;
    logic             unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata[31:WIDTH];

    // Per-bit debounce: a bit must differ from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_next_s[i] = stable_r[i];
            cnt_next_s[i]    = 16'd0;
            if (!deb_en_r) begin
                stable_next_s[i] = sync2_r[i];
            end else if (sync2_r[i] == stable_r[i]) begin
                cnt_next_s[i] = 16'd0;
            end else if (cnt_r[i] == DEB_LAST) begin
                stable_next_s[i] = sync2_r[i];
                cnt_next_s[i]    = 16'd0;
            end else begin
                cnt_next_s[i] = cnt_r[i] + 16'd1;
            end
        end
    end

    assign rise_s = stable_r & ~stable_d_r;
    assign fall_s = ~stable_r & stable_d_r;

    // Edge selection, W1C clear and register write decode; a fresh event beats a clear.
    always_comb begin
        ev_s            = rise_s | fall_s;
        clr_s           = {WIDTH{1'b0}};
        mask_next_s     = mask_r;
        deb_en_next_s   = deb_en_r;
        edge_sel_next_s = edge_sel_r;
        case (edge_sel_r)
            2'b00:   ev_s = rise_s;
            2'b01:   ev_s = fall_s;
            default: ev_s = rise_s | fall_s;
        endcase
        if (wr_s) begin
            case (address)
                ADDR_MASK: mask_next_s = writedata[WIDTH-1:0];
                ADDR_EDGE: clr_s       = writedata[WIDTH-1:0];
                ADDR_CFG: begin
                    deb_en_next_s   = writedata[0];
                    edge_sel_next_s = writedata[2:1];
                end
                default: clr_s = {WIDTH{1'b0}};
            endcase
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        edgecap_next_s = (edgecap_r & ~clr_s) | ev_s;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            ADDR_DATA: rdata_s = {{(32-WIDTH){1'b0}}, stable_r};
            ADDR_MASK: rdata_s = {{(32-WIDTH){1'b0}}, mask_r};
            ADDR_EDGE: rdata_s = {{(32-WIDTH){1'b0}}, edgecap_r};
            ADDR_CFG:  rdata_s = {29'd0, edge_sel_r, deb_en_r};
            default:   rdata_s = 32'd0;
        endcase
    end

    // State registers; reset dominates any coincident bus write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r    <= {WIDTH{1'b0}};
            sync2_r    <= {WIDTH{1'b0}};
            stable_r   <= {WIDTH{1'b0}};
            stable_d_r <= {WIDTH{1'b0}};
            mask_r     <= {WIDTH{1'b0}};
            edgecap_r  <= {WIDTH{1'b0}};
            deb_en_r   <= 1'b1;
            edge_sel_r <= 2'b00;
            readdata   <= 32'd0;
            irq        <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            sync1_r    <= in_port;
            sync2_r    <= sync1_r;
            stable_r   <= stable_next_s;
            stable_d_r <= stable_r;
            mask_r     <= mask_next_s;
            edgecap_r  <= edgecap_next_s;
            deb_en_r   <= deb_en_next_s;
            edge_sel_r <= edge_sel_next_s;
            readdata   <= rdata_s;
            irq        <= |(edgecap_next_s & mask_next_s);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

endmodule
